otp_decrypt_sequencer: RTL and testbench
========================================

OTP_DECRYPT_SEQUENCER -- requirements
Module: otp_decrypt_sequencer

Interface
REQ-001 SHALL have parameter DEFAULT_SEED, default 64'hFFFF_FFFF_FFFF_FFFF, the keystream state after reset and when a zero seed is loaded.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, cipher word offered.
REQ-005 SHALL have port in_ready, output, 1, sequencer accepts a cipher word.
REQ-006 SHALL have port chiper, input, 64, cipher word.
REQ-007 SHALL have port seed_load, input, 1, load request for a new keystream seed.
REQ-008 SHALL have port seed, input, 64, seed value.
REQ-009 SHALL have port out_valid, output, 1, plain word valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the plain word.
REQ-011 SHALL have port plain, output, 64, decrypted word.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port blk_count, output, 16, count of delivered plain words.

Function
REQ-014 SHALL implement FSM states IDLE, STAGE1, STAGE2, OUT.
REQ-015 in_ready SHALL equal (state==IDLE) && !seed_load.
REQ-016 IDLE with seed_load=1 SHALL load the keystream with seed, or with DEFAULT_SEED if seed==0, and remain in IDLE; seed_load has priority over in_valid.
REQ-017 seed_load outside IDLE SHALL be ignored.
REQ-018 IDLE with in_valid && in_ready SHALL register chiper and go to STAGE1.
REQ-019 STAGE1 SHALL register s1 = bitrev(~bitrev(chiper_reg)) ^ k, advance the keystream once, and go to STAGE2.
REQ-020 STAGE2 SHALL register plain = bitrev(~s1) ^ k, advance the keystream once, and go to OUT.
REQ-021 Here k is the current keystream state before the advance, so each block consumes exactly two consecutive keystream words.
REQ-022 Keystream advance SHALL be a 64-bit Fibonacci LFSR: next = {state[62:0], state[63]^state[62]^state[60]^state[59]}.
REQ-023 The keystream SHALL advance only in STAGE1 and STAGE2.
REQ-024 OUT SHALL hold out_valid=1 with plain stable until out_ready=1, then go to IDLE and increment blk_count modulo 2^16; FFFF wraps to 0000.
REQ-025 Latency: a handshake in cycle N SHALL give out_valid=1 in cycle N+3; minimum block interval is 4 cycles with out_ready held high.
REQ-026 out_valid SHALL be high only in OUT.

Reset
REQ-027 With rst=0 at a clock edge, the block SHALL set: state=IDLE, keystream=DEFAULT_SEED, plain=0, s1=0, chiper_reg=0, blk_count=0, out_valid=0, busy=0.
REQ-028 in_ready SHALL be 0 while rst=0.
REQ-029 Reset in any state SHALL discard the block in flight without delivering it and without incrementing blk_count.

Structure
REQ-030 Package otp_pkg SHALL hold: width constant 64, LFSR tap positions, the FSM state enum, and the DEFAULT_SEED constant.
REQ-031 The LFSR SHALL be a sub-module otp_keystream with ports clk, rst, load, load_val, advance, and state output.
REQ-032 bitrev and complement SHALL be combinational functions in otp_pkg.

Verification
REQ-033 Reset, no seed load, chiper=0, out_ready=1 -> plain=64'h0000_0000_0000_0001 at N+3, blk_count=1.
REQ-034 Second block chiper=0 immediately after REQ-033 -> plain=64'hC000_0000_0000_0007, blk_count=2.
REQ-035 seed_load=1 with seed=0 while in_valid=1 in IDLE -> in_ready=0, keystream=DEFAULT_SEED; a subsequent chiper=0 block -> plain=64'h0000_0000_0000_0001.
REQ-036 out_ready=0 for 5 cycles in OUT -> out_valid and plain stable, in_ready=0, keystream unchanged; out_ready=1 -> IDLE next cycle.
REQ-037 rst=0 asserted during STAGE2 -> no out_valid, blk_count=0, keystream=DEFAULT_SEED; next block reproduces REQ-033.
REQ-038 Preload blk_count to 16'hFFFF by force, then deliver one block -> blk_count=16'h0000.

Source files
------------

// File: rtl/otp_pkg.sv
// rtl/otp_pkg.sv - shared width, LFSR taps, FSM states and bit helpers for the OTP decrypt sequencer
package otp_pkg;

    localparam int WIDTH = 64;

    // Fibonacci LFSR feedback taps (bit positions in the keystream state)
    localparam int TAP_A = 63;
    localparam int TAP_B = 62;
    localparam int TAP_C = 60;
    localparam int TAP_D = 59;

    localparam logic [WIDTH-1:0] DEFAULT_SEED = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STAGE1 = 2'd1,
        STAGE2 = 2'd2,
        OUT    = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] complement(input logic [WIDTH-1:0] v);
        return ~v;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
    endfunction

endpackage

// File: rtl/otp_keystream.sv
// rtl/otp_keystream.sv - 64-bit Fibonacci LFSR keystream generator with load and advance
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset, returns state to RESET_SEED
//   load      load load_val into the state (has priority over advance)
//   load_val  value to load
//   advance   step the LFSR once
//   state     current keystream word
module otp_keystream
    import otp_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_SEED = otp_pkg::DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= load_val;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/otp_decrypt_sequencer.sv
// rtl/otp_decrypt_sequencer.sv - two-stage one-time-pad decrypt sequencer with ready/valid handshakes
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   cipher word offered
//   in_ready   sequencer accepts a cipher word (IDLE and no seed load)
//   chiper     cipher word
//   seed_load  keystream seed load request (honoured only in IDLE)
//   seed       seed value; zero selects DEFAULT_SEED
//   out_valid  plain word valid (OUT state only)
//   out_ready  consumer accepts the plain word
//   plain      decrypted word
//   busy       high whenever not IDLE
//   blk_count  number of delivered plain words, wraps at 2^16
module otp_decrypt_sequencer
    import otp_pkg::*;
#(
    parameter logic [63:0] DEFAULT_SEED = otp_pkg::DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] chiper,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] plain,
    output logic             busy,
    output logic [15:0]      blk_count
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] chiper_q;
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] plain_q;
    logic [15:0]      blk_count_q;
    logic [WIDTH-1:0] ks;
    logic [WIDTH-1:0] ks_load_val;
    logic             ks_load;
    logic             ks_advance;
    logic             accept;
    logic             deliver;

    // A zero seed would lock the LFSR at zero, so it maps to the default seed.
    assign ks_load_val = (seed == '0) ? DEFAULT_SEED : seed;

    otp_keystream #(
        .RESET_SEED(DEFAULT_SEED)
    ) u_keystream (
        .clk      (clk),
        .rst      (rst),
        .load     (ks_load),
        .load_val (ks_load_val),
        .advance  (ks_advance),
        .state    (ks)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; seed_load in IDLE blocks the input handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!seed_load && in_valid) state_d = STAGE1;
            STAGE1:  state_d = STAGE2;
            STAGE2:  state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        ks_load    = 1'b0;
        ks_advance = 1'b0;
        accept     = 1'b0;
        deliver    = 1'b0;
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = rst && !seed_load;
                ks_load  = seed_load;
                accept   = in_valid && rst && !seed_load;
            end
            STAGE1:  ks_advance = 1'b1;
            STAGE2:  ks_advance = 1'b1;
            OUT: begin
                out_valid = 1'b1;
                deliver   = out_ready;
            end
            default: busy = 1'b1;
        endcase
    end

    // Datapath: each block uses the keystream word present in STAGE1 and the
    // next one in STAGE2, since the LFSR steps at the end of each stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chiper_q    <= '0;
            s1_q        <= '0;
            plain_q     <= '0;
            blk_count_q <= '0;
        end else begin
            if (accept) begin
                chiper_q <= chiper;
            end
            if (state_q == STAGE1) begin
                s1_q <= bitrev(complement(bitrev(chiper_q))) ^ ks;
            end
            if (state_q == STAGE2) begin
                plain_q <= bitrev(complement(s1_q)) ^ ks;
            end
            if (deliver) begin
                blk_count_q <= blk_count_q + 16'd1;
            end
        end
    end

    assign plain     = plain_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_otp_decrypt_sequencer.sv
// tb/tb_otp_decrypt_sequencer.sv - directed self-checking bench for otp_decrypt_sequencer
module tb_otp_decrypt_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] chiper;
    logic        seed_load;
    logic [63:0] seed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plain;
    logic        busy;
    logic [15:0] blk_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otp_decrypt_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .chiper    (chiper),
        .seed_load (seed_load),
        .seed      (seed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain     (plain),
        .busy      (busy),
        .blk_count (blk_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b0;
        chiper    = '0;
        seed      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_plain", plain, 0);
        check("rst_keystream", dut.u_keystream.state, 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b1;
    endtask

    // Runs one block; stall holds out_ready low for that many cycles in OUT
    // while also poking seed_load, which must be ignored outside IDLE.
    task automatic run_block(input logic [63:0] c, input logic [63:0] exp_plain,
                             input int stall, input logic [15:0] exp_cnt,
                             input logic [63:0] exp_ks);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        chiper    = c;
        out_ready = (stall == 0);
        #1;
        check("in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chiper   = '1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 8);
        check("latency", n, 3);
        check("out_valid", out_valid, 1);
        check("plain", plain, exp_plain);
        check("ks_in_out", dut.u_keystream.state, exp_ks);
        for (int i = 0; i < stall; i++) begin
            seed_load = 1'b1;
            seed      = 64'h5;
            @(posedge clk);
            @(negedge clk);
            #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_plain", plain, exp_plain);
            check("stall_in_ready", in_ready, 0);
            check("stall_keystream", dut.u_keystream.state, exp_ks);
        end
        seed_load = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("done_busy", busy, 0);
        check("done_out_valid", out_valid, 0);
        check("blk_count", blk_count, exp_cnt);
    endtask

    task automatic load_seed(input logic [63:0] s, input logic [63:0] exp_ks);
        @(negedge clk);
        seed_load = 1'b1;
        seed      = s;
        in_valid  = 1'b1;
        chiper    = '0;
        #1;
        check("seed_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("seed_busy", busy, 0);
        check("seed_keystream", dut.u_keystream.state, exp_ks);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b0;
        chiper    = '0;
        seed      = '0;

        do_reset();
        run_block(64'h0, 64'h0000_0000_0000_0001, 0, 16'd1, 64'hFFFF_FFFF_FFFF_FFFC);
        run_block(64'h0, 64'hC000_0000_0000_0007, 0, 16'd2, 64'hFFFF_FFFF_FFFF_FFF0);

        load_seed(64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_block(64'h0, 64'h0000_0000_0000_0001, 0, 16'd3, 64'hFFFF_FFFF_FFFF_FFFC);

        load_seed(64'h1, 64'h0000_0000_0000_0001);
        run_block(64'h0, 64'h8000_0000_0000_0002, 0, 16'd4, 64'h0000_0000_0000_0004);

        do_reset();
        run_block(64'h0, 64'h0000_0000_0000_0001, 5, 16'd1, 64'hFFFF_FFFF_FFFF_FFFC);

        do_reset();
        run_block(64'h1, 64'h8000_0000_0000_0001, 0, 16'd1, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset while a block sits in STAGE2
        @(negedge clk);
        in_valid  = 1'b1;
        chiper    = 64'h0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_stage2", busy, 1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_blk_count", blk_count, 0);
        check("abort_keystream", dut.u_keystream.state, 64'hFFFF_FFFF_FFFF_FFFF);
        check("abort_busy", busy, 0);
        rst = 1'b1;
        run_block(64'h0, 64'h0000_0000_0000_0001, 0, 16'd1, 64'hFFFF_FFFF_FFFF_FFFC);

        // Counter wrap
        @(negedge clk);
        force dut.blk_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.blk_count_q;
        #1;
        check("preload_blk_count", blk_count, 16'hFFFF);
        run_block(64'h0, 64'hC000_0000_0000_0007, 0, 16'h0000, 64'hFFFF_FFFF_FFFF_FFF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
